// File: rtl/fft_pkg.sv
// fft_pkg: shared mode encodings and width helpers for the streaming FFT stages
// Contents:
//   MODE_DIT / MODE_DIF  per-beat butterfly mode encoding
//   out_width()          full-precision butterfly output width
package fft_pkg;

    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;

    // One bit of growth for the complex-product add and one for the
    // butterfly add/sub covers the worst case of both DIT and DIF.
    function automatic int out_width(input int dw, input int ww);
        return dw + ww + 2;
    endfunction

endpackage

// File: rtl/cmul_stage.sv
// cmul_stage: registered partial products of a complex multiply w * x
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   en              advance (hold when low)
//   w_re, w_im      twiddle, signed WW bits
//   x_re, x_im      operand, signed XW bits
//   rr, ii, ri, ir  registered products w_re*x_re, w_im*x_im, w_re*x_im, w_im*x_re
module cmul_stage #(
    parameter int WW = 8,
    parameter int XW = 9,
    parameter int PW = WW + XW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [WW-1:0] w_re,
    input  logic signed [WW-1:0] w_im,
    input  logic signed [XW-1:0] x_re,
    input  logic signed [XW-1:0] x_im,
    output logic signed [PW-1:0] rr,
    output logic signed [PW-1:0] ii,
    output logic signed [PW-1:0] ri,
    output logic signed [PW-1:0] ir
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr <= '0;
            ii <= '0;
            ri <= '0;
            ir <= '0;
        end else if (en) begin
            rr <= PW'(w_re) * PW'(x_re);
            ii <= PW'(w_im) * PW'(x_im);
            ri <= PW'(w_re) * PW'(x_im);
            ir <= PW'(w_im) * PW'(x_re);
        end
    end

endmodule

// File: rtl/cbutterfly_stream.sv
// cbutterfly_stream: 3-stage complex radix-2 butterfly, DIT/DIF per beat, valid/ready
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   in_valid, in_ready             input handshake (in_ready = ~stall, combinational)
//   s                              beat mode: 0 = DIT, 1 = DIF
//   a_re, a_im, b_re, b_im         operands, signed DW bits
//   w_re, w_im                     twiddle, signed WW bits
//   out_valid, out_ready           output handshake
//   out_s                          mode of the beat on the outputs
//   outa_re, outa_im               upper output, signed OW bits
//   outb_re, outb_im               lower output, signed OW bits
module cbutterfly_stream
    import fft_pkg::*;
#(
    parameter int DW = 8,
    parameter int WW = 8,
    parameter int OW = out_width(DW, WW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 s,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [WW-1:0] w_re,
    input  logic signed [WW-1:0] w_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_s,
    output logic signed [OW-1:0] outa_re,
    output logic signed [OW-1:0] outa_im,
    output logic signed [OW-1:0] outb_re,
    output logic signed [OW-1:0] outb_im
);

    localparam int XW = DW + 1;
    localparam int PW = WW + XW;

    logic                 stall, en;
    logic                 v1, v2, s1, s2;
    logic signed [DW-1:0] a_re1, a_im1, b_re1, b_im1;
    logic signed [WW-1:0] w_re1, w_im1;
    logic signed [XW-1:0] sum_re1, sum_im1, dif_re1, dif_im1;
    logic signed [XW-1:0] x_re, x_im, u_re, u_im, u_re2, u_im2;
    logic signed [PW-1:0] rr, ii, ri, ir;
    logic signed [OW-1:0] p_re, p_im, ua_re, ua_im;

    // Every stage, bubbles included, moves together; only a full output
    // register that downstream refuses can hold the pipeline.
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            s1      <= MODE_DIT;
            a_re1   <= '0;
            a_im1   <= '0;
            b_re1   <= '0;
            b_im1   <= '0;
            w_re1   <= '0;
            w_im1   <= '0;
            sum_re1 <= '0;
            sum_im1 <= '0;
            dif_re1 <= '0;
            dif_im1 <= '0;
        end else if (en) begin
            v1      <= in_valid;
            s1      <= s;
            a_re1   <= a_re;
            a_im1   <= a_im;
            b_re1   <= b_re;
            b_im1   <= b_im;
            w_re1   <= w_re;
            w_im1   <= w_im;
            sum_re1 <= XW'(a_re) + XW'(b_re);
            sum_im1 <= XW'(a_im) + XW'(b_im);
            dif_re1 <= XW'(a_re) - XW'(b_re);
            dif_im1 <= XW'(a_im) - XW'(b_im);
        end
    end

    // DIT multiplies the twiddle by b and passes a through; DIF multiplies
    // by the pre-difference and passes the pre-sum through.
    assign x_re = (s1 == MODE_DIF) ? dif_re1 : XW'(b_re1);
    assign x_im = (s1 == MODE_DIF) ? dif_im1 : XW'(b_im1);
    assign u_re = (s1 == MODE_DIF) ? sum_re1 : XW'(a_re1);
    assign u_im = (s1 == MODE_DIF) ? sum_im1 : XW'(a_im1);

    cmul_stage #(
        .WW(WW),
        .XW(XW),
        .PW(PW)
    ) u_cmul (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .w_re(w_re1),
        .w_im(w_im1),
        .x_re(x_re),
        .x_im(x_im),
        .rr  (rr),
        .ii  (ii),
        .ri  (ri),
        .ir  (ir)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2    <= 1'b0;
            s2    <= MODE_DIT;
            u_re2 <= '0;
            u_im2 <= '0;
        end else if (en) begin
            v2    <= v1;
            s2    <= s1;
            u_re2 <= u_re;
            u_im2 <= u_im;
        end
    end

    assign p_re  = OW'(rr) - OW'(ii);
    assign p_im  = OW'(ri) + OW'(ir);
    assign ua_re = OW'(u_re2);
    assign ua_im = OW'(u_im2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_s     <= MODE_DIT;
            outa_re   <= '0;
            outa_im   <= '0;
            outb_re   <= '0;
            outb_im   <= '0;
        end else if (en) begin
            out_valid <= v2;
            out_s     <= s2;
            outa_re   <= (s2 == MODE_DIF) ? ua_re : ua_re + p_re;
            outa_im   <= (s2 == MODE_DIF) ? ua_im : ua_im + p_im;
            outb_re   <= (s2 == MODE_DIF) ? p_re : ua_re - p_re;
            outb_im   <= (s2 == MODE_DIF) ? p_im : ua_im - p_im;
        end
    end

endmodule

// File: tb/tb_cbutterfly_stream.sv
// tb_cbutterfly_stream: randomized and directed scoreboard bench for cbutterfly_stream
module tb_cbutterfly_stream;

    typedef struct {
        logic s;
        int   cyc;
        int   ar, ai, br, bi;
    } exp_t;

    typedef struct {
        int acyc, ocyc;
        int ar, ai, br, bi;
    } obs_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, s;
    logic signed [7:0]  a_re, a_im, b_re, b_im, w_re, w_im;
    logic               out_valid, out_ready, out_s;
    logic signed [17:0] outa_re, outa_im, outb_re, outb_im;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_stall = 0;
    exp_t expq[$];
    obs_t obs[$];
    exp_t e;
    obs_t o;
    logic stall_prev = 1'b0;
    logic prev_s;
    logic signed [17:0] prev_ar, prev_ai, prev_br, prev_bi;

    always #5 clk = ~clk;

    cbutterfly_stream dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s        (s),
        .a_re     (a_re),
        .a_im     (a_im),
        .b_re     (b_re),
        .b_im     (b_im),
        .w_re     (w_re),
        .w_im     (w_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_s    (out_s),
        .outa_re  (outa_re),
        .outa_im  (outa_im),
        .outb_re  (outb_re),
        .outb_im  (outb_im)
    );

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    // Reference butterfly from the mathematical definition, in plain integers.
    function automatic exp_t model(input logic sm, input int ar, ai, br, bi, wr, wi, input int c);
        exp_t r;
        int pr, pi, dr, di;
        r.s = sm;
        r.cyc = c;
        if (sm) begin
            dr = ar - br;
            di = ai - bi;
            r.ar = ar + br;
            r.ai = ai + bi;
            r.br = wr * dr - wi * di;
            r.bi = wr * di + wi * dr;
        end else begin
            pr = wr * br - wi * bi;
            pi = wr * bi + wi * br;
            r.ar = ar + pr;
            r.ai = ai + pi;
            r.br = ar - pr;
            r.bi = ai - pi;
        end
        return r;
    endfunction

    // Scoreboard: everything sampled on the falling edge, where inputs and
    // outputs are settled for the handshake taken at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            expq.delete();
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (!in_ready) n_stall++;
            if (stall_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_s", out_s, prev_s);
                chk("stall_hold_a_re", outa_re, prev_ar);
                chk("stall_hold_a_im", outa_im, prev_ai);
                chk("stall_hold_b_re", outb_re, prev_br);
                chk("stall_hold_b_im", outb_im, prev_bi);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_s", out_s, e.s);
                    chk("outa_re", outa_re, e.ar);
                    chk("outa_im", outa_im, e.ai);
                    chk("outb_re", outb_re, e.br);
                    chk("outb_im", outb_im, e.bi);
                    o.acyc = e.cyc;
                    o.ocyc = cyc;
                    o.ar = int'(outa_re);
                    o.ai = int'(outa_im);
                    o.br = int'(outb_re);
                    o.bi = int'(outb_im);
                    obs.push_back(o);
                end
            end
            if (in_valid && in_ready)
                expq.push_back(model(s, int'(a_re), int'(a_im), int'(b_re), int'(b_im),
                                     int'(w_re), int'(w_im), cyc));
            stall_prev = out_valid && !out_ready;
            prev_s  = out_s;
            prev_ar = outa_re;
            prev_ai = outa_im;
            prev_br = outb_re;
            prev_bi = outb_im;
        end
    end

    task automatic send(input logic sm, input int ar, ai, br, bi, wr, wi);
        int n;
        s = sm;
        a_re = 8'(ar);
        a_im = 8'(ai);
        b_re = 8'(br);
        b_im = 8'(bi);
        w_re = 8'(wr);
        w_im = 8'(wi);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 30) begin
            n++;
            idle(1);
        end
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b1;
        s = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_s", out_s, 0);
        chk("reset_outa_re", outa_re, 0);
        chk("reset_outb_im", outb_im, 0);
        chk("reset_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);

        // T1..T4 back to back, pinned against hand-computed literals
        obs.delete();
        send(1'b0, 10, 0, 2, 0, 3, 0);
        send(1'b1, 10, 0, 2, 0, 3, 0);
        send(1'b0, 1, 2, 3, 4, 0, 1);
        send(1'b1, 5, 1, 1, 3, 1, -1);
        send(1'b0, -128, 0, -128, 0, -128, -128);
        drain();
        chk("directed_count", obs.size(), 5);
        if (obs.size() == 5) begin
            chk("t1_latency", obs[0].ocyc - obs[0].acyc, 3);
            chk("t1_outa_re", obs[0].ar, 16);
            chk("t1_outb_re", obs[0].br, 4);
            chk("t2_back_to_back", obs[1].ocyc - obs[0].ocyc, 1);
            chk("t2_outa_re", obs[1].ar, 12);
            chk("t2_outb_re", obs[1].br, 24);
            chk("t3_dit_outa_re", obs[2].ar, -3);
            chk("t3_dit_outa_im", obs[2].ai, 5);
            chk("t3_dit_outb_re", obs[2].br, 5);
            chk("t3_dit_outb_im", obs[2].bi, -1);
            chk("t3_dif_outa_re", obs[3].ar, 6);
            chk("t3_dif_outa_im", obs[3].ai, 4);
            chk("t3_dif_outb_re", obs[3].br, 2);
            chk("t3_dif_outb_im", obs[3].bi, -6);
            chk("t4_outa_re", obs[4].ar, 16256);
            chk("t4_outa_im", obs[4].ai, 16384);
            chk("t4_outb_re", obs[4].br, -16512);
            chk("t4_outb_im", obs[4].bi, -16384);
        end

        // T5: four beats with a one-cycle gap, three-cycle output stall
        obs.delete();
        n_stall = 0;
        fork
            begin
                send(1'b0, 7, -3, 11, 2, 5, -9);
                send(1'b1, -20, 4, 33, -8, -2, 6);
                idle(1);
                send(1'b0, 100, -100, -50, 25, 127, -128);
                send(1'b1, -128, 127, 127, -128, -128, -128);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 20) begin
                    n++;
                    idle(1);
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("t5_delivered", obs.size(), 4);
        chk("t5_stall_cycles", n_stall, 3);

        // Randomized mixed-mode stream with random backpressure
        for (int i = 0; i < 400; i++) begin
            s = 1'($urandom);
            a_re = 8'($urandom);
            a_im = 8'($urandom);
            b_re = 8'($urandom);
            b_im = 8'($urandom);
            w_re = 8'($urandom);
            w_im = 8'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            idle(1);
        end
        drain();

        // T6: reset with three beats in flight
        send(1'b0, 1, 1, 1, 1, 1, 1);
        send(1'b1, 2, 2, 2, 2, 2, 2);
        send(1'b0, 3, 3, 3, 3, 3, 3);
        chk("t6_inflight_valid", out_valid, 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_s", out_s, 0);
        chk("t6_rst_outa_re", outa_re, 0);
        chk("t6_rst_outa_im", outa_im, 0);
        chk("t6_rst_outb_re", outb_re, 0);
        chk("t6_rst_outb_im", outb_im, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_post_reset_quiet", out_valid, 0);
        end
        chk("t6_in_ready_after", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbutterfly_stream.md
Name: cbutterfly_stream

Overview:
Parametrised successor to the pipelined real radix-2 butterfly. It computes a complex radix-2 butterfly, with DIT or DIF selected per sample, for streaming FFT stages. The datapath is a 3-stage pipeline with a valid/ready handshake and full-precision signed outputs. It sits between the stage input buffer and the twiddle ROM on one side and the next FFT stage on the other.

Parameters:
DW, 8, signed width of each data component (a_re, a_im, b_re, b_im)
WW, 8, signed width of each twiddle component (w_re, w_im)
OW, DW+WW+2, output component width; derived, must not be overridden

Ports:
clk  input  1  clock; all state is updated on the rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset), deasserted synchronously by the integrator
in_valid  input  1  input beat is valid
in_ready  output  1  block accepts a beat this cycle
s  input  1  mode for this beat: 0 = DIT, 1 = DIF
a_re, a_im  input  DW  operand a, signed
b_re, b_im  input  DW  operand b, signed
w_re, w_im  input  WW  twiddle, signed
out_valid  output  1  output beat is valid
out_ready  input  1  downstream accepts the beat
out_s  output  1  mode of the beat currently on the outputs
outa_re, outa_im  output  OW  upper butterfly output, signed
outb_re, outb_im  output  OW  lower butterfly output, signed

Behaviour:
- Arithmetic is signed, exact, with no rounding or saturation. OW = DW+WW+2 covers the worst case of both modes.
- DIT (s=0):
  - p = w*b, computed as p_re = w_re*b_re - w_im*b_im and p_im = w_re*b_im + w_im*b_re.
  - outa = a + p, outb = a - p.
- DIF (s=1):
  - outa = a + b, sign-extended to OW.
  - d = a - b, computed at DW+1 bits; outb = w*d, with the complex product formed as in DIT.
- Pipeline stages:
  - S1 registers the inputs, s, and the DIF pre-add (a+b) and pre-sub (a-b).
  - S2 registers the four real products and the delayed a or (a+b).
  - S3 registers the final add/sub results into the output registers.
- Latency: a beat accepted at edge N is presented at edge N+3 when there is no stall. Throughput is 1 beat/cycle.
- Each stage carries a valid bit; s travels with the data, so mixed-mode streams are supported.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is a combinational path from out_ready, which the integrator must tolerate.
  - A beat is accepted when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
  - During stall, all stage registers and valid bits hold and the outputs stay stable.
  - When not stalled, the pipeline advances. Empty stages (valid=0) advance too, so bubbles collapse only at the output.
- in_valid=0 while not stalled injects a bubble: the S1 valid bit is cleared. Data registers may take don't-care values, but out_valid must be 0 for bubbles.
- Reset:
  - rst=0 immediately clears all valid bits, out_valid, out_s and all output data to 0.
  - Reset mid-stream discards every in-flight beat. No partial beat is emitted after reset release.
  - in_ready is 1 in reset and after reset.
- Simultaneous output transfer and new input acceptance in the same cycle is normal operation; no beat is lost or duplicated.
- Outputs appear in acceptance order.

Decomposition:
- Shared package (fft_pkg):
  - MODE_DIT = 1'b0, MODE_DIF = 1'b1.
  - Width helper constant or function for OW.
  - Any complex-pair typedef used across FFT stages.
- One sub-module, cmul_stage: a registered complex multiplier with an enable input. It holds the four products for S2; the final add/sub is done in the parent.
- The valid/stall control stays in the parent.

Test Plan:
- T1, DIT real (DW=WW=8): s=0, a=10+0j, b=2+0j, w=3+0j, out_ready=1 -> 3 cycles later out_valid=1, outa=16+0j, outb=4+0j, out_s=0.
- T2, DIF, issued the cycle after T1: s=1, same a, b, w -> outa=12+0j, outb=24+0j on the cycle following T1's output (back-to-back, throughput 1).
- T3, complex mixed stream:
  - DIT beat: a=1+2j, b=3+4j, w=0+1j -> outa=-3+5j, outb=5-1j.
  - Next cycle DIF beat: a=5+1j, b=1+3j, w=1-1j -> outa=6+4j, outb=2-6j.
- T4, extremes, DIT: a=-128+0j, b=-128+0j, w=-128-128j -> outa=16256+16384j, outb=-16512-16384j. There must be no wrap in the 18-bit outputs.
- T5, backpressure:
  - Stream 4 beats; hold out_ready=0 for 3 cycles once the first output is valid.
  - Required: in_ready=0 during the stall, outputs stable, all 4 beats delivered once and in order after out_ready=1.
  - A gap of in_valid=0 produces no spurious out_valid.
- T6, reset mid-operation: with 3 beats in flight, assert rst=0 between edges -> out_valid and outputs go to 0 immediately, without waiting for a clock edge. After release, with no new input, out_valid stays 0 for at least 4 cycles.
